// File: rtl/mc_pkg.sv
// Shared types for the parser -> memory-controller request path.
package mc_pkg;

  localparam int unsigned AddrWidth  = 36;
  localparam int unsigned MemopWidth = 4;
  localparam int unsigned TimeWidth  = 8;
  localparam int unsigned TagWidth   = 8;
  localparam int unsigned InstrWidth = TagWidth + TimeWidth + MemopWidth + AddrWidth;
  localparam int unsigned ReqWidth   = TimeWidth + MemopWidth + AddrWidth;

  typedef enum logic [MemopWidth-1:0] {
    READ   = 4'd0,
    WRITE  = 4'd1,
    IFETCH = 4'd2
  } memop_t;

  // cmd is kept as raw bits so illegal op codes survive until checked.
  typedef struct packed {
    logic [TagWidth-1:0]   tag;
    logic [TimeWidth-1:0]  ts;
    logic [MemopWidth-1:0] cmd;
    logic [AddrWidth-1:0]  addr;
  } parser_instr_t;

  typedef struct packed {
    logic [TimeWidth-1:0]  ts;
    logic [MemopWidth-1:0] cmd;
    logic [AddrWidth-1:0]  addr;
  } mc_req_t;

  typedef enum logic [1:0] {
    StEmpty,
    StWait,
    StIssue
  } head_state_e;

endpackage

// File: rtl/mc_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap naturally.
module mc_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [WIDTH-1:0]       rdata_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
  assign rdata      = mem[rd_ptr_q];
  assign rdata_next = mem[rd_ptr_nxt];

  // Storage is not reset: outputs are qualified by empty downstream.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mc_req_receiver.sv
// Receives parser words, enforces trace rules, queues legal requests and releases
// each to the scheduler once cur_time reaches its timestamp.
module mc_req_receiver
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 36,
  parameter int unsigned MEMOP_WIDTH  = 4,
  parameter int unsigned TIME_WIDTH   = 8,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned MAX_PER_TIME = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [TIME_WIDTH-1:0]                           cur_time,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [TAG_WIDTH+TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] in_instr,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [TIME_WIDTH-1:0]                           out_time,
  output logic [MEMOP_WIDTH-1:0]                          out_cmd,
  output logic [ADDR_WIDTH-1:0]                           out_addr,
  output logic [$clog2(DEPTH):0]                          count,
  output logic                                            err_order,
  output logic                                            err_burst,
  output logic                                            err_cmd,
  output logic [7:0]                                      drop_cnt
);

  localparam int unsigned EntryWidth = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;
  localparam int unsigned BurstWidth = $clog2(MAX_PER_TIME + 1);

  // Modulo-2^TIME_WIDTH "t is at or before now".
  function automatic logic is_due(logic [TIME_WIDTH-1:0] t, logic [TIME_WIDTH-1:0] now);
    logic [TIME_WIDTH-1:0] d;
    d = t - now;
    return d[TIME_WIDTH-1] || (d == '0);
  endfunction

  logic [TAG_WIDTH-1:0]   unused_tag;
  logic [TIME_WIDTH-1:0]  in_ts;
  logic [MEMOP_WIDTH-1:0] in_cmd;
  logic [ADDR_WIDTH-1:0]  in_addr;

  assign {unused_tag, in_ts, in_cmd, in_addr} = in_instr;

  logic [TIME_WIDTH-1:0] last_time_q;
  logic                  seen_q;
  logic [BurstWidth-1:0] burst_cnt_q;
  logic                  err_order_q, err_burst_q, err_cmd_q;
  logic [7:0]            drop_cnt_q;
  logic [TIME_WIDTH-1:0] ts_diff;

  logic take, bad_cmd, bad_order, bad_burst, same_time;
  logic hit_cmd, hit_order, hit_burst, push, drop, pop;

  assign ts_diff   = in_ts - last_time_q;
  assign same_time = (in_ts == last_time_q);
  assign take      = in_valid && in_ready;
  assign bad_cmd   = (in_cmd > MEMOP_WIDTH'(IFETCH));
  assign bad_order = seen_q && ts_diff[TIME_WIDTH-1];
  assign bad_burst = same_time && (burst_cnt_q == BurstWidth'(MAX_PER_TIME));

  // First failing rule wins.
  assign hit_cmd   = take && bad_cmd;
  assign hit_order = take && !bad_cmd && bad_order;
  assign hit_burst = take && !bad_cmd && !bad_order && bad_burst;
  assign push      = take && !bad_cmd && !bad_order && !bad_burst;
  assign drop      = take && !push;

  logic [EntryWidth-1:0]  head, head_next;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  mc_fifo #(
    .WIDTH(EntryWidth),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     ({in_ts, in_cmd, in_addr}),
    .pop       (pop),
    .rdata     (head),
    .rdata_next(head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  logic [TIME_WIDTH-1:0]  head_ts, head_next_ts;
  logic [MEMOP_WIDTH-1:0] head_cmd;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic                   head_due;

  assign head_ts      = head[EntryWidth-1 -: TIME_WIDTH];
  assign head_cmd     = head[ADDR_WIDTH +: MEMOP_WIDTH];
  assign head_addr    = head[ADDR_WIDTH-1:0];
  assign head_next_ts = head_next[EntryWidth-1 -: TIME_WIDTH];
  assign head_due     = is_due(head_ts, cur_time);

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty && head_due;
  assign pop       = out_valid && out_ready;
  assign out_time  = fifo_empty ? '0 : head_ts;
  assign out_cmd   = fifo_empty ? '0 : head_cmd;
  assign out_addr  = fifo_empty ? '0 : head_addr;
  assign count     = fifo_count;
  assign err_order = err_order_q;
  assign err_burst = err_burst_q;
  assign err_cmd   = err_cmd_q;
  assign drop_cnt  = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time_q <= '0;
      seen_q      <= 1'b0;
      burst_cnt_q <= '0;
      err_order_q <= 1'b0;
      err_burst_q <= 1'b0;
      err_cmd_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (push) begin
        last_time_q <= in_ts;
        seen_q      <= 1'b1;
        burst_cnt_q <= same_time ? burst_cnt_q + BurstWidth'(1) : BurstWidth'(1);
      end
      if (hit_cmd)   err_cmd_q   <= 1'b1;
      if (hit_order) err_order_q <= 1'b1;
      if (hit_burst) err_burst_q <= 1'b1;
      if (drop && (drop_cnt_q != 8'hff)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Head-state tracker for debug visibility; the datapath does not depend on it.
  head_state_e state_q, state_d;
  logic        last_one;

  assign last_one = (fifo_count == ($clog2(DEPTH)+1)'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (push) state_d = is_due(in_ts, cur_time) ? StIssue : StWait;
      end
      StWait: begin
        if (head_due) state_d = StIssue;
      end
      StIssue: begin
        if (pop) begin
          if (last_one && !push) begin
            state_d = StEmpty;
          end else if (last_one) begin
            state_d = is_due(in_ts, cur_time) ? StIssue : StWait;
          end else begin
            state_d = is_due(head_next_ts, cur_time) ? StIssue : StWait;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mc_req_receiver.sv
// Self-checking bench: directed vector table, corner sequences and random traffic
// against a queue-based reference model.
module tb_mc_req_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cur_time;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_time;
  logic [3:0]  out_cmd;
  logic [35:0] out_addr;
  logic [4:0]  count;
  logic        err_order, err_burst, err_cmd;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  mc_req_receiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cur_time (cur_time),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_time (out_time),
    .out_cmd  (out_cmd),
    .out_addr (out_addr),
    .count    (count),
    .err_order(err_order),
    .err_burst(err_burst),
    .err_cmd  (err_cmd),
    .drop_cnt (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of requests plus the trace-rule bookkeeping.
  typedef struct {
    int ts;
    int cmd;
    longint addr;
  } req_t;

  req_t mq[$];
  int   m_last, m_burst, m_drop;
  bit   m_seen, m_eo, m_eb, m_ec;

  function automatic int wdiff(input int a, input int b);
    int d;
    d = (((a - b) % 256) + 256) % 256;
    if (d > 127) d -= 256;
    return d;
  endfunction

  function automatic bit m_head_due();
    return (mq.size() != 0) && (wdiff(mq[0].ts, int'(cur_time)) <= 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 0; m_burst = 0; m_drop = 0;
    m_seen = 0; m_eo = 0; m_eb = 0; m_ec = 0;
  endtask

  task automatic model_edge();
    bit   take, do_pop, dropped;
    req_t r;
    take    = in_valid && (mq.size() < 16);
    do_pop  = m_head_due() && out_ready;
    dropped = 0;
    r.ts    = int'(in_instr[47:40]);
    r.cmd   = int'(in_instr[39:36]);
    r.addr  = longint'(in_instr[35:0]);
    if (do_pop) void'(mq.pop_front());
    if (take) begin
      if (r.cmd > 2) begin
        m_ec = 1; dropped = 1;
      end else if (m_seen && wdiff(r.ts, m_last) < 0) begin
        m_eo = 1; dropped = 1;
      end else if (r.ts == m_last && m_burst == 4) begin
        m_eb = 1; dropped = 1;
      end else begin
        mq.push_back(r);
        m_burst = (r.ts == m_last) ? m_burst + 1 : 1;
        m_last  = r.ts;
        m_seen  = 1;
      end
      if (dropped && m_drop < 255) m_drop++;
    end
  endtask

  task automatic compare_all();
    bit     exp_ov;
    int     et, ec;
    longint ea;
    exp_ov = m_head_due();
    et = 0; ec = 0; ea = 0;
    if (mq.size() != 0) begin
      et = mq[0].ts; ec = mq[0].cmd; ea = mq[0].addr;
    end
    check("count",     64'(count),     64'(mq.size()));
    check("in_ready",  64'(in_ready),  64'(mq.size() != 16));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("out_time",  64'(out_time),  64'(et));
    check("out_cmd",   64'(out_cmd),   64'(ec));
    check("out_addr",  64'(out_addr),  64'(ea));
    check("err_order", 64'(err_order), 64'(m_eo));
    check("err_burst", 64'(err_burst), 64'(m_eb));
    check("err_cmd",   64'(err_cmd),   64'(m_ec));
    check("drop_cnt",  64'(drop_cnt),  64'(m_drop));
  endtask

  task automatic drive(input bit v, input int ts, input int cmd, input logic [35:0] addr,
                       input bit ordy, input int now);
    in_valid  = v;
    in_instr  = {8'h00, 8'(ts), 4'(cmd), addr};
    out_ready = ordy;
    cur_time  = 8'(now);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    in_valid  = 0;
    out_ready = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    bit          vld;
    int          ts;
    int          cmd;
    logic [35:0] addr;
    bit          ordy;
    int          now;
    int          e_cnt;
    bit          e_ov;
    logic [35:0] e_addr;
    logic [2:0]  e_err;   // {order, burst, cmd}
    int          e_drop;
  } vec_t;

  function automatic vec_t mk(input bit v, input int ts, input int cmd, input logic [35:0] a,
                              input bit o, input int n, input int ecnt, input bit eov,
                              input logic [35:0] ea, input logic [2:0] ee, input int ed);
    vec_t x;
    x.vld = v; x.ts = ts; x.cmd = cmd; x.addr = a; x.ordy = o; x.now = n;
    x.e_cnt = ecnt; x.e_ov = eov; x.e_addr = ea; x.e_err = ee; x.e_drop = ed;
    return x;
  endfunction

  vec_t vecs[17];

  initial begin
    logic [35:0] ra, rb;
    int          now;

    // Basic flow
    vecs[0]  = mk(1, 5, 0, 36'h01FF97000, 0, 3, 1, 0, 36'h01FF97000, 3'b000, 0);
    vecs[1]  = mk(0, 0, 0, 36'h0, 0, 4, 1, 0, 36'h01FF97000, 3'b000, 0);
    vecs[2]  = mk(0, 0, 0, 36'h0, 0, 5, 1, 1, 36'h01FF97000, 3'b000, 0);
    vecs[3]  = mk(0, 0, 0, 36'h0, 1, 5, 0, 0, 36'h0, 3'b000, 0);
    // Burst limit: fifth word with time 10 is dropped
    for (int i = 0; i < 5; i++) begin
      vecs[4+i] = mk(1, 10, 1, 36'(16 + i), 0, 0, (i < 4) ? i + 1 : 4, 0, 36'h10,
                     (i == 4) ? 3'b010 : 3'b000, (i == 4) ? 1 : 0);
    end
    vecs[9]  = mk(0, 0, 0, 36'h0, 1, 10, 3, 1, 36'h11, 3'b010, 1);
    vecs[10] = mk(0, 0, 0, 36'h0, 1, 10, 2, 1, 36'h12, 3'b010, 1);
    vecs[11] = mk(0, 0, 0, 36'h0, 1, 10, 1, 1, 36'h13, 3'b010, 1);
    vecs[12] = mk(0, 0, 0, 36'h0, 1, 10, 0, 0, 36'h0, 3'b010, 1);
    // Backwards time, then illegal op code
    vecs[13] = mk(1, 20, 2, 36'h20, 0, 10, 1, 0, 36'h20, 3'b010, 1);
    vecs[14] = mk(1, 15, 0, 36'h15, 0, 10, 1, 0, 36'h20, 3'b110, 2);
    vecs[15] = mk(1, 20, 3, 36'h33, 0, 10, 1, 0, 36'h20, 3'b111, 3);
    vecs[16] = mk(0, 0, 0, 36'h0, 1, 20, 0, 0, 36'h0, 3'b111, 3);

    rst_n = 1;
    drive(0, 0, 0, 36'h0, 0, 0);
    model_reset();
    #1 rst_n = 0;
    #1;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].ts, vecs[i].cmd, vecs[i].addr, vecs[i].ordy, vecs[i].now);
      tick();
      check($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d.ov", i), 64'(out_valid), 64'(vecs[i].e_ov));
      check($sformatf("vec%0d.addr", i), 64'(out_addr), 64'(vecs[i].e_addr));
      check($sformatf("vec%0d.err", i), 64'({err_order, err_burst, err_cmd}),
            64'(vecs[i].e_err));
      check($sformatf("vec%0d.drop", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
    end

    // Full FIFO, blocked push, then simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, i + 1, i % 3, 36'({4'($urandom), 32'($urandom)}), 0, 0);
      tick();
    end
    check("full.in_ready", 64'(in_ready), 64'(0));
    check("full.count", 64'(count), 64'(16));
    drive(1, 17, 0, 36'h5, 0, 0);
    tick();
    check("full.blocked", 64'(count), 64'(16));
    drive(0, 0, 0, 36'h0, 1, 100);
    tick();
    check("full.pop_ready", 64'(in_ready), 64'(1));
    drive(1, 20, 1, 36'hABC, 1, 100);
    tick();
    check("full.pushpop", 64'(count), 64'(15));
    drive(0, 0, 0, 36'h0, 1, 100);
    for (int i = 0; i < 15; i++) tick();
    check("full.drained", 64'(count), 64'(0));

    // Wrap-around of the timestamp space
    do_reset();
    ra = 36'h123456789;
    rb = 36'h0FEDCBA98;
    drive(1, 252, 0, ra, 0, 250); tick();
    drive(1, 2, 1, rb, 0, 250);   tick();
    check("wrap.count", 64'(count), 64'(2));
    drive(0, 0, 0, 36'h0, 0, 251); tick();
    check("wrap.notdue", 64'(out_valid), 64'(0));
    drive(0, 0, 0, 36'h0, 0, 252); tick();
    check("wrap.due1", 64'(out_valid), 64'(1));
    check("wrap.time1", 64'(out_time), 64'(252));
    drive(0, 0, 0, 36'h0, 1, 252); tick();
    check("wrap.head2", 64'(out_time), 64'(2));
    check("wrap.wait2", 64'(out_valid), 64'(0));
    drive(0, 0, 0, 36'h0, 0, 0); tick();
    check("wrap.wait2b", 64'(out_valid), 64'(0));
    drive(0, 0, 0, 36'h0, 0, 2); tick();
    check("wrap.due2", 64'(out_valid), 64'(1));
    check("wrap.addr2", 64'(out_addr), 64'(rb));
    drive(0, 0, 0, 36'h0, 1, 2); tick();

    // Reset with entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 5 + i, i, 36'(i + 1), 0, 3);
      tick();
    end
    check("rst.pre_count", 64'(count), 64'(3));
    in_valid = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    check("rst.count", 64'(count), 64'(0));
    check("rst.ov", 64'(out_valid), 64'(0));
    check("rst.ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1;

    // Random traffic against the model
    now = 0;
    for (int c = 0; c < 3000; c++) begin
      int r, ts, cmd;
      if (c == 1500) do_reset();
      r = int'($urandom_range(19, 0));
      if (r < 4)      ts = m_last;
      else if (r < 5) ts = now - 3;
      else            ts = now + int'($urandom_range(7, 0));
      cmd = ($urandom_range(15, 0) == 0) ? 3 : int'($urandom_range(2, 0));
      drive($urandom_range(9, 0) < 7, ts, cmd, 36'({4'($urandom), 32'($urandom)}),
            $urandom_range(9, 0) < 6, now);
      tick();
      now = (now + int'($urandom_range(1, 0))) % 256;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
